// File: rtl/keyboard_rupt_gen.sv
// keyboard_rupt_gen: debounces the main/nav DSKY keycodes and the MARK button,
// latches accepted codes for channel 15/16 reads and raises the level rupt
// requests KYRPT1, KYRPT2 and MKRPT until each is cleared by its reset pulse.
module keyboard_rupt_gen #(
  parameter int DEBOUNCE_N = 4,
  parameter int KEY_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SAMPLE,
  input  logic [KEY_W-1:0] KEY1,
  input  logic [KEY_W-1:0] KEY2,
  input  logic             MARK,
  input  logic             KY1RST,
  input  logic             KY2RST,
  input  logic             MKRST,
  output logic             KYRPT1,
  output logic             KYRPT2,
  output logic             MKRPT,
  output logic [KEY_W-1:0] CH15,
  output logic [KEY_W:0]   CH16,
  output logic             KYOVF
);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} st_t;

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

  // Debounce counter increment, held at 15 rather than wrapping
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  logic [KEY_W-1:0] key1_p0, key1_p1;
  logic [KEY_W-1:0] key2_p0, key2_p1;
  logic             mark_p0, mark_p1;

  // Two-flop synchronizers for the asynchronous raw inputs
  always_ff @(posedge clk) begin
    key1_p0 <= KEY1;
    key1_p1 <= key1_p0;
    key2_p0 <= KEY2;
    key2_p1 <= key2_p0;
    mark_p0 <= MARK;
    mark_p1 <= mark_p0;
  end

  // Channel 0 = main keyboard, 1 = nav keyboard, 2 = mark button
  logic [KEY_W-1:0] chan_v   [3];
  logic [KEY_W-1:0] acc_code [3];
  logic [2:0]       acc;

  assign chan_v[0] = key1_p1;
  assign chan_v[1] = key2_p1;
  assign chan_v[2] = {{(KEY_W-1){1'b0}}, mark_p1};

  for (genvar g = 0; g < 3; g++) begin : ch
    st_t              st_q, st_d;
    logic [KEY_W-1:0] cap_q, cap_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] v;
    logic             acc_c;

    assign v = chan_v[g];

    // Channel state, captured code and debounce count
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= IDLE;
        cap_q <= '0;
        cnt_q <= 4'd0;
      end else begin
        st_q  <= st_d;
        cap_q <= cap_d;
        cnt_q <= cnt_d;
      end
    end

    // Debounce transitions, evaluated only on SAMPLE strobes
    always_comb begin
      st_d  = st_q;
      cap_d = cap_q;
      cnt_d = cnt_q;
      if (SAMPLE) begin
        case (st_q)
          IDLE: begin
            if (v != '0) begin
              cap_d = v;
              cnt_d = 4'd1;
              st_d  = (DB_N <= 4'd1) ? HELD : PRESS;
            end
          end
          PRESS: begin
            if (v == '0) begin
              st_d = IDLE;
            end else if (v != cap_q) begin
              cap_d = v;
              cnt_d = 4'd1;
            end else begin
              cnt_d = sat_inc(cnt_q);
              if (cnt_d >= DB_N) st_d = HELD;
            end
          end
          HELD: begin
            if (v == '0) begin
              cnt_d = 4'd1;
              st_d  = (DB_N <= 4'd1) ? IDLE : RELEASE;
            end
          end
          RELEASE: begin
            if (v != '0) begin
              st_d = HELD;
            end else begin
              cnt_d = sat_inc(cnt_q);
              if (cnt_d >= DB_N) st_d = IDLE;
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end

    // Accept pulse: the strobe that completes a stable press
    always_comb begin
      acc_c = 1'b0;
      if (SAMPLE) begin
        if (st_q == IDLE && v != '0 && DB_N <= 4'd1)
          acc_c = 1'b1;
        else if (st_q == PRESS && v == cap_q && sat_inc(cnt_q) >= DB_N)
          acc_c = 1'b1;
      end
    end

    assign acc[g]      = acc_c;
    assign acc_code[g] = cap_d;
  end

  logic [KEY_W-1:0] ch16_lo;

  assign CH16 = {MKRPT, ch16_lo};

  // Request flags (set beats clear), code latches and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      KYRPT1  <= 1'b0;
      KYRPT2  <= 1'b0;
      MKRPT   <= 1'b0;
      KYOVF   <= 1'b0;
      CH15    <= '0;
      ch16_lo <= '0;
    end else begin
      KYRPT1 <= acc[0] | (KYRPT1 & ~KY1RST);
      KYRPT2 <= acc[1] | (KYRPT2 & ~KY2RST);
      MKRPT  <= acc[2] | (MKRPT & ~MKRST);
      KYOVF  <= KYOVF | (acc[0] & KYRPT1) | (acc[1] & KYRPT2) | (acc[2] & MKRPT);
      if (acc[0]) CH15    <= acc_code[0];
      if (acc[1]) ch16_lo <= acc_code[1];
    end
  end

endmodule

// File: tb/tb_keyboard_rupt_gen.sv
// Testbench for keyboard_rupt_gen: scripted key/mark stimulus with expected
// output snapshots queued on each step and compared after the DUT responds.
module tb_keyboard_rupt_gen;
  localparam int KEY_W = 5;

  logic             clk = 1'b0;
  logic             rst, SAMPLE, MARK, KY1RST, KY2RST, MKRST;
  logic [KEY_W-1:0] KEY1, KEY2;
  logic             KYRPT1, KYRPT2, MKRPT, KYOVF;
  logic [KEY_W-1:0] CH15;
  logic [KEY_W:0]   CH16;

  keyboard_rupt_gen #(.DEBOUNCE_N(4), .KEY_W(KEY_W)) dut (
    .clk(clk), .rst(rst), .SAMPLE(SAMPLE), .KEY1(KEY1), .KEY2(KEY2), .MARK(MARK),
    .KY1RST(KY1RST), .KY2RST(KY2RST), .MKRST(MKRST),
    .KYRPT1(KYRPT1), .KYRPT2(KYRPT2), .MKRPT(MKRPT),
    .CH15(CH15), .CH16(CH16), .KYOVF(KYOVF)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;
  exp_t sbq[$];

  // expected-state model
  logic             e_k1 = 0, e_k2 = 0, e_mk = 0, e_ovf = 0;
  logic [KEY_W-1:0] e_ch15 = '0, e_ch16lo = '0;

  function automatic logic [14:0] observed();
    return {KYRPT1, KYRPT2, MKRPT, KYOVF, CH15, CH16};
  endfunction

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got={k1,k2,mk,ovf,ch15,ch16}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = {e_k1, e_k2, e_mk, e_ovf, e_ch15, e_mk, e_ch16lo};
    sbq.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty no expected entry queued");
    end else begin
      e = sbq.pop_front();
      chk(e.tag, observed(), e.v);
    end
  endtask

  // one SAMPLE strobe, preceded by synchronizer settling; optional clear pulses on the same clk
  task automatic smp(input bit r1 = 0, input bit r2 = 0, input bit rm = 0);
    repeat (3) @(negedge clk);
    SAMPLE = 1'b1; KY1RST = r1; KY2RST = r2; MKRST = rm;
    @(negedge clk);
    SAMPLE = 1'b0; KY1RST = 1'b0; KY2RST = 1'b0; MKRST = 1'b0;
  endtask

  task automatic smp_chk(input string tag, input bit r1 = 0);
    sb_push(tag);
    smp(r1);
    sb_pop();
  endtask

  task automatic clr_pulse(input string tag, input bit r1, input bit r2, input bit rm);
    sb_push(tag);
    @(negedge clk);
    KY1RST = r1; KY2RST = r2; MKRST = rm;
    @(negedge clk);
    KY1RST = 1'b0; KY2RST = 1'b0; MKRST = 1'b0;
    sb_pop();
  endtask

  task automatic reset_pulse(input string tag);
    sb_push(tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_pop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; SAMPLE = 0; MARK = 0; KY1RST = 0; KY2RST = 0; MKRST = 0;
    KEY1 = '0; KEY2 = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    sb_push("reset"); sb_pop();

    // 1: clean press of 5'o21
    KEY1 = 5'o21;
    smp(); smp();
    smp_chk("t1_s3_none");
    e_k1 = 1; e_ch15 = 5'o21;
    smp_chk("t1_s4_accept");
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();
    e_k1 = 0;
    clr_pulse("t1_ky1rst", 1, 0, 0);

    // 2: bounce 21,0,21 then stable
    KEY1 = 5'o21; smp();
    KEY1 = '0;    smp();
    KEY1 = 5'o21; smp(); smp();
    smp_chk("t2_s3_after_bounce");
    e_k1 = 1;
    smp_chk("t2_s4_accept");
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();
    e_k1 = 0;
    clr_pulse("t2_ky1rst", 1, 0, 0);

    // 3: held 20 samples, KY1RST at sample 6, no re-rise
    KEY1 = 5'o21;
    for (int s = 1; s <= 20; s++) begin
      if (s == 4) e_k1 = 1;
      if (s == 6) e_k1 = 0;
      smp_chk($sformatf("t3_hold_s%0d", s), s == 6);
    end
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();
    KEY1 = 5'o02;
    smp(); smp(); smp();
    e_k1 = 1; e_ch15 = 5'o02;
    smp_chk("t3_new_press");
    e_k1 = 0;
    clr_pulse("t3_ky1rst", 1, 0, 0);
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();

    // 4: MARK and KEY2 together
    MARK = 1'b1; KEY2 = 5'o13;
    smp(); smp();
    smp_chk("t4_s3_none");
    e_k2 = 1; e_mk = 1; e_ch16lo = 5'o13;
    smp_chk("t4_s4_both");
    e_mk = 0;
    clr_pulse("t4_mkrst", 0, 0, 1);
    MARK = 1'b0; KEY2 = '0;
    for (int i = 0; i < 4; i++) smp();
    e_k2 = 0;
    clr_pulse("t4_ky2rst", 0, 1, 0);

    // 5: second accept while KYRPT1 pending -> overflow
    KEY1 = 5'o21;
    smp(); smp(); smp();
    e_k1 = 1; e_ch15 = 5'o21;
    smp_chk("t5_first");
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();
    KEY1 = 5'o02;
    smp(); smp(); smp();
    e_ch15 = 5'o02; e_ovf = 1;
    smp_chk("t5_overflow");
    e_k1 = 0;
    clr_pulse("t5_ovf_sticky", 1, 0, 0);
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();

    // accept coincident with KY1RST: set wins
    KEY1 = 5'o03;
    smp(); smp(); smp();
    e_k1 = 1; e_ch15 = 5'o03;
    smp_chk("setwins", 1'b1);
    KEY1 = '0;
    for (int i = 0; i < 4; i++) smp();

    // 6: rst during PRESS (cnt=3) with key held
    KEY1 = 5'o21;
    smp(); smp(); smp();
    e_k1 = 0; e_k2 = 0; e_mk = 0; e_ovf = 0; e_ch15 = '0; e_ch16lo = '0;
    reset_pulse("t6_rst");
    smp(); smp();
    smp_chk("t6_s3_none");
    e_k1 = 1; e_ch15 = 5'o21;
    smp_chk("t6_s4_accept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
